// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for serial_subtractor.
// The master drives operands and accepts results; the slave is the subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow_out, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow_out, busy
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: computes a - b one bit per clock,
// LSB first, using a single borrow flip-flop. The result is copied into
// dedicated output registers on the last bit, so diff/borrow_out stay put
// while the shifters are reused for the next operation.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] diff_sh;
    logic [WIDTH-1:0] diff_q;
    logic             borrow;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt;

    logic             a0;
    logic             b0;
    logic             d;
    logic             borrow_next;
    logic             last_bit;
    logic [WIDTH-1:0] diff_sh_next;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;

    // One full-subtractor cell plus the shifted register images for this bit.
    // Shifting with >> and then patching the MSB keeps WIDTH=1 legal.
    always_comb begin
        a0           = a_sh[0];
        b0           = b_sh[0];
        d            = a0 ^ b0 ^ borrow;
        borrow_next  = (~a0 & b0) | (~(a0 ^ b0) & borrow);
        a_shift      = a_sh >> 1;
        b_shift      = b_sh >> 1;
        diff_sh_next = diff_sh >> 1;
        diff_sh_next[WIDTH-1] = d;
        last_bit     = (cnt == CNT_W'(WIDTH - 1));
    end

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, serialise in RUN, hold result in DONE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_next = RUN;
            RUN:     if (last_bit)      state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load operands on accept, shift one bit per RUN cycle, and
    // latch the finished result into the output registers on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            diff_sh  <= '0;
            diff_q   <= '0;
            borrow   <= 1'b0;
            borrow_q <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh    <= a_shift;
                    b_sh    <= b_shift;
                    diff_sh <= diff_sh_next;
                    borrow  <= borrow_next;
                    cnt     <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        diff_q   <= diff_sh_next;
                        borrow_q <= borrow_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Handshake flags decode straight from state; in_ready is also gated by
    // reset so nothing is offered while the block is held in reset.
    assign bus.in_ready   = (state == IDLE) && rst_n;
    assign bus.out_valid  = (state == DONE);
    assign bus.busy       = (state == RUN);
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;

endmodule
